// File: rtl/turf_regbus_pkg.sv
// turf_regbus_pkg: shared FSM encoding and sizing helpers for the TURFIO register-bus slave
package turf_regbus_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WDATA, ST_RWAIT, ST_RDATA, ST_DRAIN} state_e;
  localparam int ABORT_W = 8;
  function automatic int nbeats(input int dw, input int bw);
    return dw / bw;
  endfunction
endpackage

// File: rtl/turf_regbus_shift.sv
// turf_regbus_shift: NBEATS-beat word shifter with beat counter, shifting right with new beats entering at the top
module turf_regbus_shift
  import turf_regbus_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic [BUS_WIDTH-1:0]  beat_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  last_o,
  output logic                  busy_o
);
  localparam int NB = nbeats(DATA_WIDTH, BUS_WIDTH);
  localparam int CW = $clog2(NB);
  logic [DATA_WIDTH-1:0] sh_q;
  logic [CW-1:0]         cnt_q;
  assign word_o = sh_q;
  assign last_o = cnt_q == CW'(NB - 1);
  assign busy_o = cnt_q != '0;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= load_data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sh_q  <= {beat_i, sh_q[DATA_WIDTH-1:BUS_WIDTH]};
      cnt_q <= last_o ? '0 : cnt_q + 1'b1;
    end else if (clr_i) begin
      cnt_q <= '0;
    end
endmodule

// File: rtl/turf_regbus_slave_v3.sv
// turf_regbus_slave_v3: byte-serial TURFIO register-bus slave with burst auto-increment,
// fixed-latency read handshake and abort counting
module turf_regbus_slave_v3
  import turf_regbus_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cs_n_i,
  input  logic                  wnr_i,
  input  logic [BUS_WIDTH-1:0]  bus_d_i,
  output logic [BUS_WIDTH-1:0]  bus_d_o,
  output logic                  bus_oe_o,
  output logic [ADDR_BITS-1:0]  reg_addr_o,
  output logic                  reg_wr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  reg_rd_o,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  output logic [ABORT_W-1:0]    abort_cnt_o,
  output logic [2:0]            state_o
);
  logic                  cs_q, wnr_q;
  logic [BUS_WIDTH-1:0]  d_q;
  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d, reg_addr_q, reg_addr_d;
  logic [2:0]            lat_q, lat_d;
  logic                  wr_q, wr_d, rd_q, rd_d, oe_q, oe_d, abort;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, wr_word, rd_word;
  logic [ABORT_W-1:0]    abort_q;
  logic                  wr_shift, wr_last, wr_busy, rd_load, rd_shift, rd_last, rd_busy;
  logic                  unused;
  turf_regbus_shift #(.BUS_WIDTH(BUS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(state_q == ST_IDLE), .load_i(1'b0),
    .shift_i(wr_shift), .load_data_i('0), .beat_i(d_q), .word_o(wr_word),
    .last_o(wr_last), .busy_o(wr_busy)
  );
  turf_regbus_shift #(.BUS_WIDTH(BUS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(1'b0), .load_i(rd_load),
    .shift_i(rd_shift), .load_data_i(reg_rdata_i), .beat_i('0), .word_o(rd_word),
    .last_o(rd_last), .busy_o(rd_busy)
  );
  assign unused = ^{wr_word[BUS_WIDTH-1:0], rd_word[DATA_WIDTH-1:BUS_WIDTH], rd_busy};
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    reg_addr_d = reg_addr_q;
    lat_d      = lat_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    oe_d       = 1'b0;
    abort      = 1'b0;
    wr_shift   = 1'b0;
    rd_load    = 1'b0;
    rd_shift   = 1'b0;
    case (state_q)
      ST_IDLE: if (!cs_q) begin
        addr_d     = d_q[ADDR_BITS-1:0];
        reg_addr_d = d_q[ADDR_BITS-1:0];
        lat_d      = '0;
        rd_d       = !wnr_q;
        state_d    = wnr_q ? ST_WDATA : ST_RWAIT;
      end
      ST_WDATA: begin
        abort    = cs_q && wr_busy;
        wr_shift = !cs_q;
        if (cs_q) state_d = ST_IDLE;
        else if (wr_last) begin
          wr_d       = 1'b1;
          wdata_d    = {d_q, wr_word[DATA_WIDTH-1:BUS_WIDTH]};
          reg_addr_d = addr_q;
          addr_d     = addr_q + 1'b1;
        end
      end
      ST_RWAIT: begin
        abort   = cs_q;
        rd_load = !cs_q && lat_q == 3'(RD_LATENCY);
        oe_d    = rd_load;
        lat_d   = lat_q + 1'b1;
        state_d = cs_q ? ST_IDLE : rd_load ? ST_RDATA : ST_RWAIT;
      end
      ST_RDATA: begin
        abort    = cs_q && !rd_last;
        rd_shift = !abort;
        oe_d     = !cs_q && !rd_last;
        rd_d     = rd_last && !cs_q;
        lat_d    = '0;
        addr_d     = rd_d ? addr_q + 1'b1 : addr_q;
        reg_addr_d = rd_d ? addr_q + 1'b1 : reg_addr_q;
        state_d  = abort ? ST_IDLE : !rd_last ? ST_RDATA : cs_q ? ST_DRAIN : ST_RWAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cs_q       <= 1'b1;
      wnr_q      <= 1'b0;
      d_q        <= '0;
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      reg_addr_q <= '0;
      lat_q      <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      oe_q       <= 1'b0;
      wdata_q    <= '0;
      abort_q    <= '0;
    end else begin
      cs_q       <= cs_n_i;
      wnr_q      <= wnr_i;
      d_q        <= bus_d_i;
      state_q    <= state_d;
      addr_q     <= addr_d;
      reg_addr_q <= reg_addr_d;
      lat_q      <= lat_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      oe_q       <= oe_d;
      wdata_q    <= wdata_d;
      abort_q    <= (abort && abort_q != '1) ? abort_q + 1'b1 : abort_q;
    end
  assign bus_d_o     = rd_word[BUS_WIDTH-1:0];
  assign bus_oe_o    = oe_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wr_o    = wr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_rd_o    = rd_q;
  assign abort_cnt_o = abort_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_turf_regbus_slave_v3.sv
// tb_turf_regbus_slave_v3: directed bench for the register-bus slave at read latency 1 and 3
module tb_turf_regbus_slave_v3;
  logic clk = 1'b0, rst_n = 1'b0, cs1_n = 1'b1, cs3_n = 1'b1, wnr = 1'b0, sel = 1'b0;
  logic [7:0]  d = '0;
  logic [7:0]  bd1, bd3, addr1, addr3, ab1, ab3, ea;
  logic        oe1, oe3, wr1, wr3, rd1, rd3;
  logic [31:0] wd1, wd3, rdat1, rdat3, w;
  logic [2:0]  st1, st3;
  logic [2:0]  pipe1 = '0, pipe3 = '0;
  logic [31:0] ws [3];
  int tests = 0, failed = 0, wr_cnt1 = 0, rd_cnt3 = 0, beats3 = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] regval(input logic [7:0] a);
    return a == 8'h00 ? 32'h54555246 : a == 8'h10 ? 32'hA1B2C3D4 : a == 8'h11 ? 32'h0BADF00D : 32'h0;
  endfunction

  // read data is only valid exactly RD_LATENCY cycles after the strobe is sampled
  assign rdat1 = pipe1[0] ? regval(addr1) : 32'hDEADBEEF;
  assign rdat3 = pipe3[2] ? regval(addr3) : 32'hDEADBEEF;
  always @(posedge clk) begin
    pipe1 <= {pipe1[1:0], rd1};
    pipe3 <= {pipe3[1:0], rd3};
  end

  turf_regbus_slave_v3 #(.RD_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .cs_n_i(cs1_n), .wnr_i(wnr), .bus_d_i(d),
    .bus_d_o(bd1), .bus_oe_o(oe1), .reg_addr_o(addr1), .reg_wr_o(wr1), .reg_wdata_o(wd1),
    .reg_rd_o(rd1), .reg_rdata_i(rdat1), .abort_cnt_o(ab1), .state_o(st1)
  );
  turf_regbus_slave_v3 #(.RD_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .cs_n_i(cs3_n), .wnr_i(wnr), .bus_d_i(d),
    .bus_d_o(bd3), .bus_oe_o(oe3), .reg_addr_o(addr3), .reg_wr_o(wr3), .reg_wdata_o(wd3),
    .reg_rd_o(rd3), .reg_rdata_i(rdat3), .abort_cnt_o(ab3), .state_o(st3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic wn, input logic [7:0] b);
    cs1_n = sel ? 1'b1 : c;
    cs3_n = sel ? c : 1'b1;
    wnr   = wn;
    d     = b;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (wr1) wr_cnt1++;
    if (rd3) rd_cnt3++;
    if (oe3) beats3++;
    if (wr1 || rd1) chk("strobe_excl", {31'b0, wr1 & rd1}, 32'h0);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oe", oe1, 0); chk("rst_wr", wr1, 0); chk("rst_rd", rd1, 0);
    chk("rst_addr", addr1, 0); chk("rst_wdata", wd1, 0); chk("rst_abort", ab1, 0);
    chk("rst_state", st1, 0); chk("rst_bd", bd1, 0);
    rst_n = 1'b1;
    step(1, 0, 0); step(1, 0, 0);

    // single write to 0x06
    step(0, 1, 8'h06); step(0, 1, 8'h78); step(0, 1, 8'h56); step(0, 1, 8'h34); step(0, 1, 8'h12);
    step(1, 0, 0);
    chk("t1_wr", wr1, 1); chk("t1_addr", addr1, 8'h06); chk("t1_wdata", wd1, 32'h12345678);
    step(1, 0, 0);
    chk("t1_wr_off", wr1, 0); chk("t1_state", st1, 0); chk("t1_abort", ab1, 0); chk("t1_wr_cnt", wr_cnt1, 1);

    // single read of 0x00, latency 1
    step(0, 0, 8'h00);
    step(0, 0, 0);
    chk("t2_rd", rd1, 1); chk("t2_addr", addr1, 0);
    step(0, 0, 0);
    chk("t2_rd_off", rd1, 0); chk("t2_oe_wait", oe1, 0);
    w = 32'h54555246;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 0, 0);
      chk("t2_oe", oe1, 1); chk("t2_beat", bd1, w[8*i +: 8]);
    end
    step(1, 0, 0);
    chk("t2_oe_off", oe1, 0); chk("t2_drain", st1, 3'd4);
    step(1, 0, 0);
    chk("t2_idle", st1, 0); chk("t2_abort", ab1, 0);

    // write burst from 0xFF wrapping through 0x00, 0x01
    ws[0] = 32'h11223344; ws[1] = 32'h55667788; ws[2] = 32'h99AABBCC;
    ea = 8'hFF;
    step(0, 1, 8'hFF);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, ws[i/4][8*(i%4) +: 8]);
      if (i % 4 == 0 && i > 0) begin
        chk("t3_wr", wr1, 1); chk("t3_addr", addr1, ea); chk("t3_wdata", wd1, ws[i/4-1]);
        ea = ea + 8'h01;
      end
      if (i == 5) chk("t3_wr_pulse", wr1, 0);
    end
    step(1, 0, 0);
    chk("t3_wr_last", wr1, 1); chk("t3_addr_last", addr1, 8'h01); chk("t3_wdata_last", wd1, ws[2]);
    step(1, 0, 0);
    chk("t3_wr_cnt", wr_cnt1, 4); chk("t3_state", st1, 0);

    // read burst of two words from 0x10, latency 3
    sel = 1'b1;
    step(0, 0, 8'h10);
    step(0, 0, 0);
    chk("t4_rd0", rd3, 1); chk("t4_addr0", addr3, 8'h10);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); chk("t4_wait0_oe", oe3, 0); end
    w = 32'hA1B2C3D4;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      chk("t4_oe0", oe3, 1); chk("t4_beat0", bd3, w[8*i +: 8]);
    end
    step(0, 0, 0);
    chk("t4_rd1", rd3, 1); chk("t4_addr1", addr3, 8'h11); chk("t4_gap_oe", oe3, 0);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); chk("t4_wait1_oe", oe3, 0); end
    w = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 0, 0);
      chk("t4_oe1", oe3, 1); chk("t4_beat1", bd3, w[8*i +: 8]);
    end
    step(1, 0, 0);
    chk("t4_oe_off", oe3, 0); chk("t4_drain", st3, 3'd4);
    step(1, 0, 0);
    chk("t4_idle", st3, 0); chk("t4_beats", beats3, 8); chk("t4_rd_cnt", rd_cnt3, 2); chk("t4_abort", ab3, 0);
    sel = 1'b0;

    // write aborted after two beats, then saturation
    step(0, 1, 8'h20); step(0, 1, 8'hAA); step(0, 1, 8'hBB); step(1, 0, 0); step(1, 0, 0);
    chk("t5_abort1", ab1, 1); chk("t5_state", st1, 0); chk("t5_no_wr", wr_cnt1, 4);
    for (int i = 0; i < 254; i++) begin
      step(0, 1, 8'h20); step(0, 1, 8'hAA); step(0, 1, 8'hBB); step(1, 0, 0); step(1, 0, 0);
    end
    chk("t5_abort255", ab1, 255);
    for (int i = 0; i < 45; i++) begin
      step(0, 1, 8'h20); step(0, 1, 8'hAA); step(0, 1, 8'hBB); step(1, 0, 0); step(1, 0, 0);
    end
    chk("t5_abort_sat", ab1, 255); chk("t5_no_wr_end", wr_cnt1, 4);

    // async reset in the middle of a read data phase
    step(0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("t6_oe_pre", oe1, 1); chk("t6_beat_pre", bd1, 8'h52);
    rst_n = 1'b0;
    #1;
    chk("t6_oe_rst", oe1, 0); chk("t6_state_rst", st1, 0); chk("t6_abort_rst", ab1, 0);
    chk("t6_rd_rst", rd1, 0); chk("t6_wr_rst", wr1, 0);
    step(1, 0, 0); step(1, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0);
    step(0, 1, 8'h2A); step(0, 1, 8'h0D); step(0, 1, 8'hF0); step(0, 1, 8'hFE); step(0, 1, 8'hCA);
    step(1, 0, 0);
    chk("t6_wr", wr1, 1); chk("t6_addr", addr1, 8'h2A); chk("t6_wdata", wd1, 32'hCAFEF00D);
    step(1, 0, 0);
    chk("t6_state", st1, 0); chk("t6_abort", ab1, 0); chk("t6_wr_cnt", wr_cnt1, 5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
